// File: rtl/onewire_sn_master.sv
// 1-wire serial-number master: reset/presence, multi-bit write and read.
// Commands arrive as a toggle from the tck domain; completion is a toggle back.
module onewire_sn_master #(
    parameter int DW     = 8,
    parameter int NW     = 4,
    parameter int CW     = 15,
    parameter int T_RST  = 19200,
    parameter int T_PD   = 2800,
    parameter int T_RREC = 16400,
    parameter int T_W0   = 2400,
    parameter int T_W1   = 240,
    parameter int T_RS   = 360,
    parameter int T_SLOT = 2800,
    parameter int T_REC  = 400
) (
    input  logic          clk,
    input  logic          hard_rst,
    input  logic          req_tgl,
    input  logic [1:0]    cmd,
    input  logic [NW-1:0] nbits,
    input  logic [DW-1:0] wdata,
    input  logic          sn_in,
    output logic          sn_out,
    output logic [DW-1:0] rdata,
    output logic          presence,
    output logic          err,
    output logic          busy,
    output logic          done_tgl
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_RST_LOW,
        S_RST_WAIT,
        S_RST_REC,
        S_SLOT_LOW,
        S_SLOT_REL,
        S_RECOV,
        S_FINISH
    } state_e;

    localparam logic [1:0] C_RST = 2'b00;
    localparam logic [1:0] C_WR  = 2'b01;
    localparam logic [1:0] C_RD  = 2'b10;

    localparam logic [CW-1:0] L_RST  = CW'(T_RST - 1);
    localparam logic [CW-1:0] L_PD   = CW'(T_PD - 1);
    localparam logic [CW-1:0] L_RREC = CW'(T_RREC - 1);
    localparam logic [CW-1:0] L_W0   = CW'(T_W0 - 1);
    localparam logic [CW-1:0] L_W1   = CW'(T_W1 - 1);
    localparam logic [CW-1:0] L_SLOT = CW'(T_SLOT - 1);
    localparam logic [CW-1:0] L_REC  = CW'(T_REC - 1);
    localparam logic [CW-1:0] C_RS   = CW'(T_RS);

    logic          req_s1_q, req_s2_q, req_s3_q;
    logic          sn_s1_q, sn_s2_q;
    logic          req;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] idx_q, idx_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [NW-1:0] nb_q, nb_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          pres_q, pres_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sn_out_q, sn_out_d;

    logic [DW-1:0] sel;
    logic [DW-1:0] keep;
    logic          cur_bit;
    logic          last_bit;
    logic [CW-1:0] t_low;

    // Synchronisers load 0 so a request already pending at reset release is seen
    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            req_s1_q <= 1'b0;
            req_s2_q <= 1'b0;
            req_s3_q <= 1'b0;
            sn_s1_q  <= 1'b0;
            sn_s2_q  <= 1'b0;
        end else begin
            req_s1_q <= req_tgl;
            req_s2_q <= req_s1_q;
            req_s3_q <= req_s2_q;
            sn_s1_q  <= sn_in;
            sn_s2_q  <= sn_s1_q;
        end
    end

    assign req = req_s2_q ^ req_s3_q;

    assign sel      = DW'(1) << idx_q;
    assign cur_bit  = |(wd_q & sel);
    assign last_bit = (idx_q == nb_q - NW'(1));
    assign t_low    = (cmd_q == C_WR && !cur_bit) ? L_W0 : L_W1;

    always_comb begin
        keep = '0;
        for (int j = 0; j < DW; j++) begin
            keep[j] = (j < int'(nb_q));
        end
    end

    always_ff @(posedge clk or negedge hard_rst) begin
        if (!hard_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            cmd_q    <= 2'b11;
            nb_q     <= '0;
            wd_q     <= '0;
            rdata_q  <= '0;
            pres_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sn_out_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            cmd_q    <= cmd_d;
            nb_q     <= nb_d;
            wd_q     <= wd_d;
            rdata_q  <= rdata_d;
            pres_q   <= pres_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sn_out_q <= sn_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        nb_d    = nb_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        pres_d  = pres_q;
        err_d   = err_q;
        done_d  = done_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req) begin
                    state_d = S_START;
                    cmd_d   = cmd;
                    nb_d    = (int'(nbits) > DW) ? NW'(DW) : nbits;
                    wd_d    = wdata;
                    idx_d   = '0;
                end
            end
            S_START: begin
                cnt_d = '0;
                if (!sn_s2_q) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    err_d = 1'b0;
                    if (cmd_q == C_RST) begin
                        state_d = S_RST_LOW;
                    end else if (cmd_q == C_WR || cmd_q == C_RD) begin
                        state_d = (nb_q != '0) ? S_SLOT_LOW : S_FINISH;
                        if (cmd_q == C_RD) begin
                            rdata_d = rdata_q & keep;
                        end
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_RST_LOW: begin
                if (cnt_q == L_RST) begin
                    state_d = S_RST_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == L_PD) begin
                    pres_d  = ~sn_s2_q;
                    state_d = S_RST_REC;
                    cnt_d   = '0;
                end
            end
            S_RST_REC: begin
                if (cnt_q == L_RREC) begin
                    state_d = S_FINISH;
                    cnt_d   = '0;
                end
            end
            S_SLOT_LOW: begin
                // Counter keeps running into SLOT_REL so slot length is absolute
                if (cnt_q == t_low) begin
                    state_d = S_SLOT_REL;
                end
            end
            S_SLOT_REL: begin
                if (cmd_q == C_RD && cnt_q == C_RS) begin
                    rdata_d = sn_s2_q ? (rdata_q | sel) : (rdata_q & ~sel);
                end
                if (cnt_q == L_SLOT) begin
                    state_d = S_RECOV;
                    cnt_d   = '0;
                end
            end
            S_RECOV: begin
                if (cnt_q == L_REC) begin
                    cnt_d = '0;
                    if (last_bit) begin
                        state_d = S_FINISH;
                    end else if (!sn_s2_q) begin
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + NW'(1);
                        state_d = S_SLOT_LOW;
                    end
                end
            end
            S_FINISH: begin
                cnt_d   = '0;
                done_d  = ~done_q;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Registered from next state so the pin edge lands on the state-entry edge
        sn_out_d = ~(state_d == S_RST_LOW || state_d == S_SLOT_LOW);
        busy_d   = (state_d != S_IDLE);
    end

    assign sn_out   = sn_out_q;
    assign rdata    = rdata_q;
    assign presence = pres_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign done_tgl = done_q;

endmodule

// File: tb/tb_onewire_sn_master.sv
// Directed bench for onewire_sn_master with an open-drain line model.
// Device models: presence pulse after reset, LSB-first read responder.
module tb_onewire_sn_master;

    localparam int T_RST  = 40;
    localparam int T_PD   = 20;
    localparam int T_RREC = 30;
    localparam int T_W0   = 24;
    localparam int T_W1   = 6;
    localparam int T_RS   = 12;
    localparam int T_SLOT = 30;
    localparam int T_REC  = 8;

    logic       clk = 1'b0;
    logic       hard_rst = 1'b0;
    logic       req_tgl = 1'b0;
    logic [1:0] cmd = 2'b11;
    logic [3:0] nbits = '0;
    logic [7:0] wdata = '0;
    logic       sn_in;
    logic       sn_out;
    logic [7:0] rdata;
    logic       presence;
    logic       err;
    logic       busy;
    logic       done_tgl;

    logic dev_pres_n = 1'b1;
    logic dev_rd_n = 1'b1;
    logic stuck_n = 1'b1;
    bit   pres_mode = 1'b0;
    bit   rd_mode = 1'b0;
    logic [7:0] rd_pat = '0;
    int   rd_i = 0;

    int errors = 0;
    int checks = 0;

    int lens[$];
    int falls[$];
    int lo_cnt = 0;
    int cyc = 0;
    logic sn_prev = 1'b1;
    int done_cnt = 0;
    logic done_prev = 1'b0;

    assign sn_in = sn_out & dev_pres_n & dev_rd_n & stuck_n;

    onewire_sn_master #(
        .DW(8), .NW(4), .CW(15),
        .T_RST(T_RST), .T_PD(T_PD), .T_RREC(T_RREC),
        .T_W0(T_W0), .T_W1(T_W1), .T_RS(T_RS),
        .T_SLOT(T_SLOT), .T_REC(T_REC)
    ) dut (
        .clk(clk),
        .hard_rst(hard_rst),
        .req_tgl(req_tgl),
        .cmd(cmd),
        .nbits(nbits),
        .wdata(wdata),
        .sn_in(sn_in),
        .sn_out(sn_out),
        .rdata(rdata),
        .presence(presence),
        .err(err),
        .busy(busy),
        .done_tgl(done_tgl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled mid-cycle
    always @(negedge clk) begin
        if (!sn_out) begin
            if (sn_prev) falls.push_back(cyc);
            lo_cnt = lo_cnt + 1;
        end else if (lo_cnt != 0) begin
            lens.push_back(lo_cnt);
            lo_cnt = 0;
        end
        sn_prev = sn_out;
        if (done_tgl !== done_prev) begin
            done_cnt = done_cnt + 1;
            done_prev = done_tgl;
        end
    end

    always begin
        @(posedge sn_out);
        if (pres_mode) begin
            repeat (10) @(posedge clk);
            dev_pres_n = 1'b0;
            repeat (25) @(posedge clk);
            dev_pres_n = 1'b1;
        end
    end

    always begin
        @(negedge sn_out);
        if (rd_mode) begin
            if (!rd_pat[rd_i[2:0]]) begin
                dev_rd_n = 1'b0;
                repeat (T_RS + 6) @(posedge clk);
                dev_rd_n = 1'b1;
            end
            rd_i = rd_i + 1;
        end
    end

    task automatic run_cmd(input logic [1:0] c, input logic [3:0] n,
                           input logic [7:0] w, output int busy_cyc,
                           output bit to);
        logic d0;
        d0 = done_tgl;
        cmd = c;
        nbits = n;
        wdata = w;
        @(negedge clk);
        req_tgl = ~req_tgl;
        busy_cyc = 0;
        to = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done_tgl !== d0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset_state;
        @(negedge clk);
        checks++;
        if ({sn_out, rdata, presence, err, busy, done_tgl} !== 13'h1000) begin
            errors++;
            $display("FAIL reset_state: got %0h want 1000",
                     {sn_out, rdata, presence, err, busy, done_tgl});
        end
        hard_rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_tgl !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0 0",
                     busy, done_tgl);
        end
    endtask

    task automatic test_reset_presence;
        int bc;
        bit to;
        int d0;
        lens.delete();
        pres_mode = 1'b1;
        d0 = done_cnt;
        run_cmd(2'b00, 4'd0, 8'h00, bc, to);
        repeat (50) @(negedge clk);
        pres_mode = 1'b0;
        checks++;
        if (to) begin
            errors++;
            $display("FAIL rst_timeout: done never toggled");
        end
        checks++;
        if (lens.size() != 1 || lens[0] != T_RST) begin
            errors++;
            $display("FAIL rst_low_len: got n=%0d len=%0d want 1 %0d",
                     lens.size(), lens.size() ? lens[0] : -1, T_RST);
        end
        checks++;
        if (presence !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_presence: pres=%b err=%b want 1 0",
                     presence, err);
        end
        checks++;
        if (bc != 2 + T_RST + T_PD + T_RREC) begin
            errors++;
            $display("FAIL rst_busy_len: got %0d want %0d",
                     bc, 2 + T_RST + T_PD + T_RREC);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL rst_done_cnt: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_nodev;
        int bc;
        bit to;
        int d0;
        d0 = done_cnt;
        run_cmd(2'b00, 4'd0, 8'h00, bc, to);
        repeat (5) @(negedge clk);
        checks++;
        if (to || presence !== 1'b0 || err !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL rst_nodev: to=%b pres=%b err=%b dn=%0d want 0 0 0 1",
                     to, presence, err, done_cnt - d0);
        end
    endtask

    task automatic test_write;
        int bc;
        bit to;
        int exp_len[4];
        bit bad;
        exp_len = '{T_W1, T_W0, T_W1, T_W0};
        lens.delete();
        falls.delete();
        run_cmd(2'b01, 4'd4, 8'h05, bc, to);
        repeat (3) @(negedge clk);
        checks++;
        bad = to || lens.size() != 4;
        for (int i = 0; i < 4 && !bad; i++) bad = (lens[i] != exp_len[i]);
        if (bad) begin
            errors++;
            $display("FAIL write_lens: n=%0d l0=%0d l1=%0d want 4 %0d %0d",
                     lens.size(), lens.size() > 0 ? lens[0] : -1,
                     lens.size() > 1 ? lens[1] : -1, T_W1, T_W0);
        end
        checks++;
        bad = falls.size() != 4;
        for (int i = 1; i < 4 && !bad; i++)
            bad = (falls[i] - falls[i-1] != T_SLOT + T_REC);
        if (bad) begin
            errors++;
            $display("FAIL write_period: n=%0d d=%0d want %0d",
                     falls.size(), falls.size() > 1 ? falls[1] - falls[0] : -1,
                     T_SLOT + T_REC);
        end
        checks++;
        if (rdata !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL write_rdata: rdata=%0h err=%b want 0 0", rdata, err);
        end
    endtask

    task automatic test_read8(input logic [7:0] pat);
        int bc;
        bit to;
        bit bad;
        lens.delete();
        rd_pat = pat;
        rd_i = 0;
        rd_mode = 1'b1;
        run_cmd(2'b10, 4'd8, 8'h00, bc, to);
        rd_mode = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (to || rdata !== pat || err !== 1'b0) begin
            errors++;
            $display("FAIL read8: rdata=%0h err=%b to=%b want %0h 0 0",
                     rdata, err, to, pat);
        end
        checks++;
        bad = lens.size() != 8;
        for (int i = 0; i < 8 && !bad; i++) bad = (lens[i] != T_W1);
        if (bad) begin
            errors++;
            $display("FAIL read8_lens: n=%0d want 8 of %0d", lens.size(), T_W1);
        end
    endtask

    task automatic test_read3_drop;
        int d0;
        logic t0;
        bit to;
        d0 = done_cnt;
        t0 = done_tgl;
        rd_pat = 8'h05;
        rd_i = 0;
        rd_mode = 1'b1;
        cmd = 2'b10;
        nbits = 4'd3;
        @(negedge clk);
        req_tgl = ~req_tgl;
        repeat (50) @(negedge clk);
        req_tgl = ~req_tgl;
        to = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (done_tgl !== t0) begin
                to = 1'b0;
                break;
            end
        end
        repeat (200) @(negedge clk);
        rd_mode = 1'b0;
        checks++;
        if (to || rdata !== 8'h05) begin
            errors++;
            $display("FAIL read3: rdata=%0h to=%b want 05 0", rdata, to);
        end
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_req: done_cnt=%0d busy=%b want 1 0",
                     done_cnt - d0, busy);
        end
    endtask

    task automatic test_stuck;
        int bc;
        bit to;
        stuck_n = 1'b0;
        repeat (5) @(negedge clk);
        lens.delete();
        run_cmd(2'b01, 4'd4, 8'h0F, bc, to);
        repeat (3) @(negedge clk);
        checks++;
        if (to || err !== 1'b1 || lens.size() != 0 || lo_cnt != 0) begin
            errors++;
            $display("FAIL stuck: to=%b err=%b pulses=%0d want 0 1 0",
                     to, err, lens.size());
        end
        stuck_n = 1'b1;
        repeat (5) @(negedge clk);
        run_cmd(2'b11, 4'd0, 8'h00, bc, to);
        checks++;
        if (to || err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: to=%b err=%b want 0 0", to, err);
        end
    endtask

    task automatic test_hard_rst;
        bit to;
        cmd = 2'b01;
        nbits = 4'd8;
        wdata = 8'h00;
        @(negedge clk);
        req_tgl = ~req_tgl;
        to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!sn_out) begin
                to = 1'b0;
                break;
            end
        end
        repeat (5) @(posedge clk);
        #2;
        hard_rst = 1'b0;
        #1;
        checks++;
        if (to || sn_out !== 1'b1 || busy !== 1'b0 || done_tgl !== 1'b0 ||
            rdata !== 8'h00 || presence !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL hard_rst: to=%b sn=%b busy=%b done=%b want 0 1 0 0",
                     to, sn_out, busy, done_tgl);
        end
        req_tgl = 1'b1;
        cmd = 2'b11;
        repeat (3) @(negedge clk);
        hard_rst = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_tgl === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to || busy !== 1'b0) begin
            errors++;
            $display("FAIL pending_req: done=%b busy=%b want 1 0",
                     done_tgl, busy);
        end
    endtask

    initial begin
        test_reset_state();
        test_reset_presence();
        test_reset_nodev();
        test_write();
        test_read8(8'hA3);
        test_read8(8'hFF);
        test_read3_drop();
        test_stuck();
        test_hard_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
